// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline types, widths, ALU encodings and the bubble
//               control bundle used by the ID/EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 16;
  localparam int ALUOP_W   = 4;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd9;

  // RUN: normal flow; HOLD: EX unit busy, ID/EX frozen
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  // A bubble carries no side effects: every control bit cleared
  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Decode/write-back/EX-control bundle into the ID/EX stage and
//               the registered ID_EX_* bundle plus stall/counters out of it.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) ();
  logic             IF_ID_Valid;
  logic [REG_W-1:0] IF_ID_Rs1, IF_ID_Rs2, IF_ID_Rd;
  logic             ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc;
  logic [3:0]       ID_ALUOp;
  logic [XLEN-1:0]  ID_Read_Data1, ID_Read_Data2, ID_Imm, ID_PC;
  logic             MEM_WB_RegWrite;
  logic [REG_W-1:0] MEM_WB_Rd;
  logic [XLEN-1:0]  MEM_WB_Write_Data;
  logic             EX_Busy;
  logic             Flush;

  logic             ID_EX_Valid;
  logic [REG_W-1:0] ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
  logic             ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc;
  logic [3:0]       ID_EX_ALUOp;
  logic [XLEN-1:0]  ID_EX_Data1, ID_EX_Data2, ID_EX_Imm, ID_EX_PC;
  logic             Stall;
  logic [CNT_W-1:0] Stall_Count, Bubble_Count;

  // Pipeline environment: drives decode/WB/EX control, observes the stage
  modport master (
    output IF_ID_Valid, IF_ID_Rs1, IF_ID_Rs2, IF_ID_Rd,
    output ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_ALUOp,
    output ID_Read_Data1, ID_Read_Data2, ID_Imm, ID_PC,
    output MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_Write_Data, EX_Busy, Flush,
    input  ID_EX_Valid, ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd,
    input  ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc,
    input  ID_EX_ALUOp, ID_EX_Data1, ID_EX_Data2, ID_EX_Imm, ID_EX_PC,
    input  Stall, Stall_Count, Bubble_Count
  );

  // The ID/EX stage itself
  modport slave (
    input  IF_ID_Valid, IF_ID_Rs1, IF_ID_Rs2, IF_ID_Rd,
    input  ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_ALUOp,
    input  ID_Read_Data1, ID_Read_Data2, ID_Imm, ID_PC,
    input  MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_Write_Data, EX_Busy, Flush,
    output ID_EX_Valid, ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd,
    output ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc,
    output ID_EX_ALUOp, ID_EX_Data1, ID_EX_Data2, ID_EX_Imm, ID_EX_PC,
    output Stall, Stall_Count, Bubble_Count
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use detection and front-end stall request.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  wire logic             ex_valid,
  input  wire logic             ex_mem_read,
  input  wire logic [REG_W-1:0] ex_rd,
  input  wire logic             id_valid,
  input  wire logic [REG_W-1:0] id_rs1,
  input  wire logic [REG_W-1:0] id_rs2,
  input  wire logic             ex_busy,
  input  wire logic             flush,
  output logic                  load_use,
  output logic                  stall
);

  // A load in EX whose result the decoding instruction needs; x0 never counts
  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    stall    = (load_use || ex_busy) && !flush;
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use bubble insertion,
//               EX-busy hold, flush, write-back bypass and saturating
//               stall/bubble performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  id_ex_stage_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [REG_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [XLEN-1:0]  data1_q, data1_d, data2_q, data2_d, imm_q, imm_d, pc_q, pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  logic  load_use;
  logic  stall;
  ctrl_t id_ctrl;
  logic  wb_hit;

  assign id_ctrl = {bus.ID_RegWrite, bus.ID_MemRead, bus.ID_MemWrite,
                    bus.ID_MemToReg, bus.ID_ALUSrc, bus.ID_ALUOp};
  assign wb_hit  = bus.MEM_WB_RegWrite && (bus.MEM_WB_Rd != '0);

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .id_valid    (bus.IF_ID_Valid),
    .id_rs1      (bus.IF_ID_Rs1),
    .id_rs2      (bus.IF_ID_Rs2),
    .ex_busy     (bus.EX_Busy),
    .flush       (bus.Flush),
    .load_use    (load_use),
    .stall       (stall)
  );

  // HOLD tracks an outstanding EX-busy freeze; a flush always returns to RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (bus.EX_Busy && !bus.Flush) state_d = ST_HOLD;
      ST_HOLD: if (!bus.EX_Busy || bus.Flush) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Per-edge action in priority order: flush, hold, load-use bubble, capture
  always_comb begin
    valid_d      = valid_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    ctrl_d       = ctrl_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    imm_d        = imm_q;
    pc_d         = pc_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (bus.Flush || (!bus.EX_Busy && load_use)) begin
      valid_d = 1'b0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      ctrl_d  = BUBBLE_CTRL;
      data1_d = '0;
      data2_d = '0;
      imm_d   = '0;
      pc_d    = '0;
      bubble_cnt_d = sat_inc(bubble_cnt_q);
      if (!bus.Flush) stall_cnt_d = sat_inc(stall_cnt_q);
    end else if (bus.EX_Busy) begin
      // Frozen instruction still picks up values retiring past it
      if (wb_hit && (bus.MEM_WB_Rd == rs1_q)) data1_d = bus.MEM_WB_Write_Data;
      if (wb_hit && (bus.MEM_WB_Rd == rs2_q)) data2_d = bus.MEM_WB_Write_Data;
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      valid_d = bus.IF_ID_Valid;
      rs1_d   = bus.IF_ID_Rs1;
      rs2_d   = bus.IF_ID_Rs2;
      rd_d    = bus.IF_ID_Rd;
      ctrl_d  = bus.IF_ID_Valid ? id_ctrl : BUBBLE_CTRL;
      // Covers the register file not yet reflecting the same-cycle write
      data1_d = (wb_hit && (bus.MEM_WB_Rd == bus.IF_ID_Rs1)) ? bus.MEM_WB_Write_Data
                                                             : bus.ID_Read_Data1;
      data2_d = (wb_hit && (bus.MEM_WB_Rd == bus.IF_ID_Rs2)) ? bus.MEM_WB_Write_Data
                                                             : bus.ID_Read_Data2;
      imm_d   = bus.ID_Imm;
      pc_d    = bus.ID_PC;
    end
  end

  // Pipeline register, FSM and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      valid_q      <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      ctrl_q       <= BUBBLE_CTRL;
      data1_q      <= '0;
      data2_q      <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      ctrl_q       <= ctrl_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ID_EX_Valid    = valid_q;
  assign bus.ID_EX_Rs1      = rs1_q;
  assign bus.ID_EX_Rs2      = rs2_q;
  assign bus.ID_EX_Rd       = rd_q;
  assign bus.ID_EX_RegWrite = ctrl_q.reg_write;
  assign bus.ID_EX_MemRead  = ctrl_q.mem_read;
  assign bus.ID_EX_MemWrite = ctrl_q.mem_write;
  assign bus.ID_EX_MemToReg = ctrl_q.mem_to_reg;
  assign bus.ID_EX_ALUSrc   = ctrl_q.alu_src;
  assign bus.ID_EX_ALUOp    = ctrl_q.alu_op;
  assign bus.ID_EX_Data1    = data1_q;
  assign bus.ID_EX_Data2    = data2_q;
  assign bus.ID_EX_Imm      = imm_q;
  assign bus.ID_EX_PC       = pc_q;
  assign bus.Stall          = stall;
  assign bus.Stall_Count    = stall_cnt_q;
  assign bus.Bubble_Count   = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage: directed scenarios plus
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  localparam int CMAX  = 65535;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit        valid;
    bit [4:0]  rs1, rs2, rd;
    bit        rw, mr, mw, m2r, as;
    bit [3:0]  op;
    bit [31:0] d1, d2, imm, pc;
    int        sc, bc;
  } model_t;

  model_t m = '{default: 0};
  model_t nx;
  int checks = 0;
  int errors = 0;

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  function automatic bit model_lu();
    return m.valid && m.mr && (m.rd != 0) && bus.IF_ID_Valid &&
           ((m.rd == bus.IF_ID_Rs1) || (m.rd == bus.IF_ID_Rs2));
  endfunction

  // What the EX slot must hold after the coming edge
  function automatic model_t predict();
    model_t r;
    bit     wb;
    r  = m;
    wb = bus.MEM_WB_RegWrite && (bus.MEM_WB_Rd != 0);
    if (!reset_n) begin
      r = '{default: 0};
    end else if (bus.Flush) begin
      r = '{default: 0};
      r.sc = m.sc;
      r.bc = sat(m.bc);
    end else if (bus.EX_Busy) begin
      if (wb && bus.MEM_WB_Rd == m.rs1) r.d1 = bus.MEM_WB_Write_Data;
      if (wb && bus.MEM_WB_Rd == m.rs2) r.d2 = bus.MEM_WB_Write_Data;
      r.sc = sat(m.sc);
    end else if (model_lu()) begin
      r = '{default: 0};
      r.sc = sat(m.sc);
      r.bc = sat(m.bc);
    end else begin
      r.valid = bus.IF_ID_Valid;
      r.rs1 = bus.IF_ID_Rs1;
      r.rs2 = bus.IF_ID_Rs2;
      r.rd  = bus.IF_ID_Rd;
      r.rw  = bus.IF_ID_Valid && bus.ID_RegWrite;
      r.mr  = bus.IF_ID_Valid && bus.ID_MemRead;
      r.mw  = bus.IF_ID_Valid && bus.ID_MemWrite;
      r.m2r = bus.IF_ID_Valid && bus.ID_MemToReg;
      r.as  = bus.IF_ID_Valid && bus.ID_ALUSrc;
      r.op  = bus.IF_ID_Valid ? bus.ID_ALUOp : 4'd0;
      r.d1  = (wb && bus.MEM_WB_Rd == bus.IF_ID_Rs1) ? bus.MEM_WB_Write_Data : bus.ID_Read_Data1;
      r.d2  = (wb && bus.MEM_WB_Rd == bus.IF_ID_Rs2) ? bus.MEM_WB_Write_Data : bus.ID_Read_Data2;
      r.imm = bus.ID_Imm;
      r.pc  = bus.ID_PC;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model each cycle
  always @(negedge clk) begin
    chk("valid",    bus.ID_EX_Valid,    m.valid);
    chk("rs1",      bus.ID_EX_Rs1,      m.rs1);
    chk("rs2",      bus.ID_EX_Rs2,      m.rs2);
    chk("rd",       bus.ID_EX_Rd,       m.rd);
    chk("regwrite", bus.ID_EX_RegWrite, m.rw);
    chk("memread",  bus.ID_EX_MemRead,  m.mr);
    chk("memwrite", bus.ID_EX_MemWrite, m.mw);
    chk("memtoreg", bus.ID_EX_MemToReg, m.m2r);
    chk("alusrc",   bus.ID_EX_ALUSrc,   m.as);
    chk("aluop",    bus.ID_EX_ALUOp,    m.op);
    chk("data1",    bus.ID_EX_Data1,    m.d1);
    chk("data2",    bus.ID_EX_Data2,    m.d2);
    chk("imm",      bus.ID_EX_Imm,      m.imm);
    chk("pc",       bus.ID_EX_PC,       m.pc);
    chk("stall",    bus.Stall,          (model_lu() || bus.EX_Busy) && !bus.Flush);
    chk("stall_cnt",  bus.Stall_Count,  m.sc);
    chk("bubble_cnt", bus.Bubble_Count, m.bc);
  end

  task automatic cyc();
    nx = predict();
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic clear_inputs();
    bus.IF_ID_Valid = 0; bus.IF_ID_Rs1 = 0; bus.IF_ID_Rs2 = 0; bus.IF_ID_Rd = 0;
    bus.ID_RegWrite = 0; bus.ID_MemRead = 0; bus.ID_MemWrite = 0;
    bus.ID_MemToReg = 0; bus.ID_ALUSrc = 0; bus.ID_ALUOp = 0;
    bus.ID_Read_Data1 = 0; bus.ID_Read_Data2 = 0; bus.ID_Imm = 0; bus.ID_PC = 0;
    bus.MEM_WB_RegWrite = 0; bus.MEM_WB_Rd = 0; bus.MEM_WB_Write_Data = 0;
    bus.EX_Busy = 0; bus.Flush = 0;
  endtask

  task automatic set_inst(input bit v, input int rs1, input int rs2, input int rd,
                          input bit rw, input bit mr, input logic [31:0] pc);
    bus.IF_ID_Valid = v;
    bus.IF_ID_Rs1 = 5'(rs1); bus.IF_ID_Rs2 = 5'(rs2); bus.IF_ID_Rd = 5'(rd);
    bus.ID_RegWrite = rw; bus.ID_MemRead = mr; bus.ID_MemToReg = mr;
    bus.ID_PC = pc;
  endtask

  task automatic rand_inputs();
    bus.IF_ID_Valid = ($urandom % 5) != 0;
    bus.IF_ID_Rs1 = 5'($urandom_range(0, 7));
    bus.IF_ID_Rs2 = 5'($urandom_range(0, 7));
    bus.IF_ID_Rd  = 5'($urandom_range(0, 7));
    bus.ID_RegWrite = 1'($urandom);
    bus.ID_MemRead  = ($urandom % 3) == 0;
    bus.ID_MemWrite = 1'($urandom);
    bus.ID_MemToReg = 1'($urandom);
    bus.ID_ALUSrc   = 1'($urandom);
    bus.ID_ALUOp    = 4'($urandom);
    bus.ID_Read_Data1 = $urandom; bus.ID_Read_Data2 = $urandom;
    bus.ID_Imm = $urandom; bus.ID_PC = $urandom;
    bus.MEM_WB_RegWrite = 1'($urandom);
    bus.MEM_WB_Rd = 5'($urandom_range(0, 7));
    bus.MEM_WB_Write_Data = $urandom;
    bus.EX_Busy = ($urandom % 5) == 0;
    bus.Flush   = ($urandom % 10) == 0;
  endtask

  initial begin
    clear_inputs();
    #1 reset_n = 1'b0;

    // Reset with busy-looking inputs: everything stays zero
    set_inst(1, 1, 2, 3, 1, 0, 32'h100);
    bus.ID_Read_Data1 = 32'h11; bus.ID_Imm = 32'h44;
    cyc(); cyc();
    chk("rst_valid", bus.ID_EX_Valid, 0);
    chk("rst_pc", bus.ID_EX_PC, 0);
    chk("rst_regwrite", bus.ID_EX_RegWrite, 0);
    reset_n = 1'b1;
    cyc();
    chk("rel_pc", bus.ID_EX_PC, 32'h100);
    chk("rel_valid", bus.ID_EX_Valid, 1);

    // Load-use: lw x5 then add using x5
    set_inst(1, 1, 2, 5, 1, 1, 32'h104);
    cyc();
    set_inst(1, 5, 6, 8, 1, 0, 32'h108);
    #1 chk("lu_stall", bus.Stall, 1);
    cyc();
    chk("lu_bubble_valid", bus.ID_EX_Valid, 0);
    chk("lu_bubble_rw", bus.ID_EX_RegWrite, 0);
    chk("lu_stall_clear", bus.Stall, 0);
    cyc();
    chk("lu_add_valid", bus.ID_EX_Valid, 1);
    chk("lu_add_rd", bus.ID_EX_Rd, 8);
    chk("lu_stall_cnt", bus.Stall_Count, 1);
    chk("lu_bubble_cnt", bus.Bubble_Count, 1);

    // x0 guard: load to x0 never stalls, write-back to x0 never bypasses
    set_inst(1, 1, 2, 0, 1, 1, 32'h10C);
    cyc();
    set_inst(1, 0, 0, 9, 1, 0, 32'h110);
    bus.ID_Read_Data1 = 32'h55; bus.ID_Read_Data2 = 32'h66;
    bus.MEM_WB_RegWrite = 1; bus.MEM_WB_Rd = 0; bus.MEM_WB_Write_Data = 32'hDEAD;
    #1 chk("x0_stall", bus.Stall, 0);
    cyc();
    chk("x0_data1", bus.ID_EX_Data1, 32'h55);
    chk("x0_data2", bus.ID_EX_Data2, 32'h66);

    // WB bypass on capture, then during a 3-cycle hold
    set_inst(1, 3, 7, 10, 1, 0, 32'h200);
    bus.ID_Read_Data1 = 32'h11; bus.ID_Read_Data2 = 32'h0;
    bus.MEM_WB_Rd = 7; bus.MEM_WB_Write_Data = 32'h1234;
    cyc();
    chk("byp_data2", bus.ID_EX_Data2, 32'h1234);
    chk("byp_data1", bus.ID_EX_Data1, 32'h11);
    set_inst(1, 4, 4, 4, 0, 0, 32'h999);
    bus.EX_Busy = 1;
    bus.MEM_WB_Rd = 3; bus.MEM_WB_Write_Data = 32'hAA;
    cyc(); cyc(); cyc();
    chk("hold_data1", bus.ID_EX_Data1, 32'hAA);
    chk("hold_data2", bus.ID_EX_Data2, 32'h1234);
    chk("hold_pc", bus.ID_EX_PC, 32'h200);
    chk("hold_rd", bus.ID_EX_Rd, 10);
    chk("hold_stall_cnt", bus.Stall_Count, 4);
    bus.EX_Busy = 0; bus.MEM_WB_RegWrite = 0;

    // Flush beats EX_Busy and load-use together
    set_inst(1, 1, 2, 4, 1, 1, 32'h300);
    cyc();
    set_inst(1, 4, 1, 11, 1, 0, 32'h304);
    bus.EX_Busy = 1; bus.Flush = 1;
    #1 chk("fl_stall", bus.Stall, 0);
    cyc();
    chk("fl_valid", bus.ID_EX_Valid, 0);
    chk("fl_bubble_cnt", bus.Bubble_Count, 2);
    chk("fl_stall_cnt", bus.Stall_Count, 4);
    bus.EX_Busy = 0; bus.Flush = 0;
    cyc();
    chk("fl_after_pc", bus.ID_EX_PC, 32'h304);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cyc();
    end

    // Saturation of the stall counter
    clear_inputs();
    bus.EX_Busy = 1;
    for (int i = 0; i < 65540; i++) cyc();
    chk("sat_stall_cnt", bus.Stall_Count, 16'hFFFF);
    cyc();
    chk("sat_stall_hold", bus.Stall_Count, 16'hFFFF);

    // Asynchronous reset in the middle of a hold
    #2 reset_n = 1'b0;
    m = '{default: 0};
    #1;
    chk("mid_rst_valid", bus.ID_EX_Valid, 0);
    chk("mid_rst_cnt", bus.Stall_Count, 0);
    reset_n = 1'b1;
    bus.EX_Busy = 0;
    set_inst(1, 1, 2, 3, 1, 0, 32'h400);
    cyc();
    chk("resume_valid", bus.ID_EX_Valid, 1);
    chk("resume_pc", bus.ID_EX_PC, 32'h400);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
